rf_wport_arbiter: RTL and testbench

- Shares the single register-file write port between two requesters:
  - the in-order pipeline writeback, as requester P;
  - an out-of-band long-latency unit (divider / late load return), as requester L.
- Sits between the writeback stage, the long-latency unit and the register file; drives the RF write port and the difftest debug_wb_* signals.
- L results are buffered in a small FIFO and drained into idle write-port cycles. A starvation counter guarantees L forward progress.
- Exports a per-register busy mask so decode can stall on RAW and WAW hazards against pending L writes.

---
 rtl/rf_wport_arbiter_pkg.sv | 25 ++
 rtl/wb_side_fifo.sv | 66 ++++++
 rtl/rf_wport_arbiter.sv | 125 ++++++++++++
 tb/tb_rf_wport_arbiter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/rf_wport_arbiter_pkg.sv
// Shared widths, bundle layouts and helpers for the RF write-port arbiter.
package rf_wport_arbiter_pkg;

    localparam int RF_ADDR_WID  = 5;
    localparam int RF_DATA_WID  = 32;
    localparam int LQ_ENTRY_WID = RF_ADDR_WID + RF_DATA_WID + 32;
    localparam int ENT_WID      = RF_ADDR_WID + 1;

    typedef struct packed {
        logic [RF_ADDR_WID-1:0] dest;
        logic [RF_DATA_WID-1:0] data;
        logic [31:0]            pc;
    } lq_entry_t;

    typedef struct packed {
        logic                   we;
        logic [RF_ADDR_WID-1:0] dest;
        logic [RF_DATA_WID-1:0] data;
    } wrf_bus_t;

    function automatic logic [31:0] dec5(input logic [RF_ADDR_WID-1:0] a);
        dec5 = 32'd1 << a;
    endfunction

endpackage

// File: rtl/wb_side_fifo.sv
// Buffer for long-latency results awaiting a free RF write-port cycle.
module wb_side_fifo
    import rf_wport_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      push,
    input  logic [LQ_ENTRY_WID-1:0]   push_data,
    input  logic                      pop,
    output logic                      full,
    output logic                      empty,
    output logic [LQ_ENTRY_WID-1:0]   head,
    output logic [DEPTH*ENT_WID-1:0]  ent
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]             wptr;
    logic [AW:0]             rptr;
    logic [AW-1:0]           widx;
    logic [AW-1:0]           ridx;
    logic [DEPTH-1:0]        vld;
    logic [LQ_ENTRY_WID-1:0] mem [DEPTH];
    logic                    do_push;
    logic                    do_pop;

    assign widx    = wptr[AW-1:0];
    assign ridx    = rptr[AW-1:0];
    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (widx == ridx);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[ridx];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr <= '0;
            rptr <= '0;
            vld  <= '0;
        end else begin
            if (do_push) begin
                vld[widx] <= 1'b1;
                wptr      <= wptr + (AW+1)'(1);
            end
            if (do_pop) begin
                vld[ridx] <= 1'b0;
                rptr      <= rptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[widx] <= push_data;
        end
    end

    // Per-entry {valid,dest} so the parent can build its busy mask.
    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        assign ent[i*ENT_WID +: ENT_WID] =
            {vld[i], mem[i][LQ_ENTRY_WID-1 -: RF_ADDR_WID]};
    end

endmodule

// File: rtl/rf_wport_arbiter.sv
// Shares the RF write port between pipeline writeback (P) and
// buffered long-latency results (L), with starvation-bounded L drain.
module rf_wport_arbiter
    import rf_wport_arbiter_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        p_valid,
    output logic        p_ready,
    input  logic        p_we,
    input  logic [4:0]  p_dest,
    input  logic [31:0] p_data,
    input  logic [31:0] p_pc,
    input  logic        l_valid,
    output logic        l_ready,
    input  logic [4:0]  l_dest,
    input  logic [31:0] l_data,
    input  logic [31:0] l_pc,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] rf_busy,
    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_we,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

    logic                     full;
    logic                     empty;
    logic                     p_use;
    logic                     force_l;
    logic                     gp;
    logic                     gl;
    logic                     push;
    lq_entry_t                push_ent;
    lq_entry_t                head;
    logic [DEPTH*ENT_WID-1:0] ent;
    logic [SW-1:0]            starve_cnt;
    wrf_bus_t                 wb_q;
    logic [31:0]              pc_q;
    logic                     src_l;
    logic [31:0]              busy;

    assign p_use    = p_valid && p_we && (p_dest != '0);
    assign force_l  = (starve_cnt == SMAX) && !empty;
    assign p_ready  = !force_l;
    assign gp       = p_use && !force_l;
    assign gl       = !empty && !gp;
    assign l_ready  = !full;
    assign push     = l_valid && !full;
    assign push_ent = '{dest: l_dest, data: l_data, pc: l_pc};

    wb_side_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rstn     (rstn),
        .push     (push),
        .push_data(push_ent),
        .pop      (gl),
        .full     (full),
        .empty    (empty),
        .head     (head),
        .ent      (ent)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            starve_cnt <= '0;
        end else if (empty || gl) begin
            starve_cnt <= '0;
        end else if (starve_cnt != SMAX) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wb_q  <= '0;
            pc_q  <= '0;
            src_l <= 1'b0;
        end else if (gp) begin
            wb_q  <= '{we: 1'b1, dest: p_dest, data: p_data};
            pc_q  <= p_pc;
            src_l <= 1'b0;
        end else if (gl) begin
            wb_q  <= '{we: (head.dest != '0), dest: head.dest, data: head.data};
            pc_q  <= head.pc;
            src_l <= 1'b1;
        end else begin
            wb_q.we <= 1'b0;
        end
    end

    // An L write stays visible as busy through the cycle it lands in the RF.
    always_comb begin
        busy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent[i*ENT_WID + RF_ADDR_WID]) begin
                busy = busy | dec5(ent[i*ENT_WID +: RF_ADDR_WID]);
            end
        end
        if (wb_q.we && src_l) begin
            busy = busy | dec5(wb_q.dest);
        end
        busy[0] = 1'b0;
    end

    assign rf_busy           = busy;
    assign rf_we             = wb_q.we;
    assign rf_waddr          = wb_q.dest;
    assign rf_wdata          = wb_q.data;
    assign debug_wb_pc       = pc_q;
    assign debug_wb_rf_we    = {4{wb_q.we}};
    assign debug_wb_rf_wnum  = wb_q.dest;
    assign debug_wb_rf_wdata = wb_q.data;

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Directed table-driven bench for rf_wport_arbiter (DEPTH=2, STARVE_MAX=4).
module tb_rf_wport_arbiter;

    localparam logic [31:0] P_PC_OFS = 32'h8000_0000;
    localparam logic [31:0] L_PC_OFS = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        rstn;
    logic        p_valid, p_we, p_ready;
    logic [4:0]  p_dest;
    logic [31:0] p_data, p_pc;
    logic        l_valid, l_ready;
    logic [4:0]  l_dest;
    logic [31:0] l_data, l_pc;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, rf_busy, debug_wb_pc, debug_wb_rf_wdata;
    logic [3:0]  debug_wb_rf_we;
    logic [4:0]  debug_wb_rf_wnum;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rf_wport_arbiter #(
        .DEPTH(2),
        .STARVE_MAX(4)
    ) dut (
        .clk              (clk),
        .rstn             (rstn),
        .p_valid          (p_valid),
        .p_ready          (p_ready),
        .p_we             (p_we),
        .p_dest           (p_dest),
        .p_data           (p_data),
        .p_pc             (p_pc),
        .l_valid          (l_valid),
        .l_ready          (l_ready),
        .l_dest           (l_dest),
        .l_data           (l_data),
        .l_pc             (l_pc),
        .rf_we            (rf_we),
        .rf_waddr         (rf_waddr),
        .rf_wdata         (rf_wdata),
        .rf_busy          (rf_busy),
        .debug_wb_pc      (debug_wb_pc),
        .debug_wb_rf_we   (debug_wb_rf_we),
        .debug_wb_rf_wnum (debug_wb_rf_wnum),
        .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    typedef struct {
        logic        pv;
        logic        pwe;
        logic [4:0]  pd;
        logic [31:0] pdat;
        logic        lv;
        logic [4:0]  ld;
        logic [31:0] ldat;
        logic        epr;
        logic        elr;
        logic        ewe;
        logic [4:0]  ea;
        logic [31:0] ed;
        logic        esl;
        logic [31:0] eb;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic pv, input logic pwe, input logic [4:0] pd,
                       input logic [31:0] pdat, input logic lv,
                       input logic [4:0] ld, input logic [31:0] ldat,
                       input logic epr, input logic elr, input logic ewe,
                       input logic [4:0] ea, input logic [31:0] ed,
                       input logic esl, input logic [31:0] eb);
        vec_t v;
        v = '{pv, pwe, pd, pdat, lv, ld, ldat, epr, elr, ewe, ea, ed, esl, eb};
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        p_valid = 1'b0; p_we = 1'b0; p_dest = '0; p_data = '0; p_pc = '0;
        l_valid = 1'b0; l_dest = '0; l_data = '0; l_pc = '0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, " rf_we"}, {31'd0, rf_we}, 32'd0);
        chk({tag, " rf_busy"}, rf_busy, 32'd0);
        chk({tag, " p_ready"}, {31'd0, p_ready}, 32'd1);
        chk({tag, " l_ready"}, {31'd0, l_ready}, 32'd1);
        chk({tag, " dbg_we"}, {28'd0, debug_wb_rf_we}, 32'd0);
    endtask

    initial begin
        idle_inputs();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        chk("reset rf_waddr", {27'd0, rf_waddr}, 32'd0);
        chk("reset rf_wdata", rf_wdata, 32'd0);
        chk("reset debug_wb_pc", debug_wb_pc, 32'd0);
        rstn = 1'b1;

        // P write r5 with idle FIFO
        add(1,1,5,32'h1234, 0,0,0,        1,1, 1,5,32'h1234,0, 32'h0);
        add(0,0,0,0,        0,0,0,        1,1, 0,0,0,0,        32'h0);
        // single L push to r7, drained into idle slot
        add(0,0,0,0,        1,7,32'hAA,   1,1, 0,0,0,0,        32'h80);
        add(0,0,0,0,        0,0,0,        1,1, 1,7,32'hAA,1,   32'h80);
        add(0,0,0,0,        0,0,0,        1,1, 0,0,0,0,        32'h0);
        // continuous P traffic starves L until the counter saturates
        add(1,1,1,32'h11,   1,2,32'h22,   1,1, 1,1,32'h11,0,   32'h4);
        add(1,1,1,32'h12,   0,0,0,        1,1, 1,1,32'h12,0,   32'h4);
        add(1,1,1,32'h13,   0,0,0,        1,1, 1,1,32'h13,0,   32'h4);
        add(1,1,1,32'h14,   0,0,0,        1,1, 1,1,32'h14,0,   32'h4);
        add(1,1,1,32'h15,   0,0,0,        1,1, 1,1,32'h15,0,   32'h4);
        add(1,1,1,32'h16,   0,0,0,        0,1, 1,2,32'h22,1,   32'h4);
        add(1,1,1,32'h16,   0,0,0,        1,1, 1,1,32'h16,0,   32'h0);
        add(0,0,0,0,        0,0,0,        1,1, 0,0,0,0,        32'h0);
        // duplicate r3 pushes fill the FIFO while P holds the port
        add(1,1,10,32'hA1,  1,3,32'h31,   1,1, 1,10,32'hA1,0,  32'h8);
        add(1,1,10,32'hA2,  1,3,32'h32,   1,1, 1,10,32'hA2,0,  32'h8);
        add(1,1,10,32'hA3,  1,9,32'h91,   1,0, 1,10,32'hA3,0,  32'h8);
        add(0,0,0,0,        1,9,32'h91,   1,0, 1,3,32'h31,1,   32'h8);
        add(0,0,0,0,        1,9,32'h91,   1,1, 1,3,32'h32,1,   32'h208);
        add(0,0,0,0,        0,0,0,        1,1, 1,9,32'h91,1,   32'h200);
        add(0,0,0,0,        0,0,0,        1,1, 0,0,0,0,        32'h0);
        // P with p_we=0 does not block a pending L entry
        add(0,0,0,0,        1,4,32'h44,   1,1, 0,0,0,0,        32'h10);
        add(1,0,6,32'h66,   0,0,0,        1,1, 1,4,32'h44,1,   32'h10);
        // L entry to r0: popped, no write, no busy bit
        add(0,0,0,0,        1,0,32'h55,   1,1, 0,0,0,0,        32'h0);
        add(0,0,0,0,        0,0,0,        1,1, 0,0,0,0,        32'h0);
        add(0,0,0,0,        0,0,0,        1,1, 0,0,0,0,        32'h0);
        // two entries left pending for the reset sequence
        add(1,1,11,32'hB1,  1,12,32'hC1,  1,1, 1,11,32'hB1,0,  32'h1000);
        add(1,1,11,32'hB2,  1,13,32'hC2,  1,1, 1,11,32'hB2,0,  32'h3000);

        for (int i = 0; i < tbl.size(); i++) begin
            string t;
            logic [31:0] epc;
            t = $sformatf("v%0d", i);
            p_valid = tbl[i].pv;
            p_we    = tbl[i].pwe;
            p_dest  = tbl[i].pd;
            p_data  = tbl[i].pdat;
            p_pc    = tbl[i].pdat + P_PC_OFS;
            l_valid = tbl[i].lv;
            l_dest  = tbl[i].ld;
            l_data  = tbl[i].ldat;
            l_pc    = tbl[i].ldat + L_PC_OFS;
            #1;
            chk({t, " p_ready"}, {31'd0, p_ready}, {31'd0, tbl[i].epr});
            chk({t, " l_ready"}, {31'd0, l_ready}, {31'd0, tbl[i].elr});
            @(posedge clk);
            #1;
            chk({t, " rf_we"}, {31'd0, rf_we}, {31'd0, tbl[i].ewe});
            chk({t, " rf_busy"}, rf_busy, tbl[i].eb);
            chk({t, " dbg_we"}, {28'd0, debug_wb_rf_we}, {28'd0, {4{tbl[i].ewe}}});
            if (tbl[i].ewe) begin
                epc = tbl[i].ed + (tbl[i].esl ? L_PC_OFS : P_PC_OFS);
                chk({t, " rf_waddr"}, {27'd0, rf_waddr}, {27'd0, tbl[i].ea});
                chk({t, " rf_wdata"}, rf_wdata, tbl[i].ed);
                chk({t, " dbg_pc"}, debug_wb_pc, epc);
                chk({t, " dbg_wnum"}, {27'd0, debug_wb_rf_wnum}, {27'd0, tbl[i].ea});
                chk({t, " dbg_wdata"}, debug_wb_rf_wdata, tbl[i].ed);
            end
        end

        // FIFO now full with r12/r13 pending
        idle_inputs();
        #1;
        chk("pre-reset l_ready", {31'd0, l_ready}, 32'd0);
        chk("pre-reset rf_busy", rf_busy, 32'h3000);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        check_reset_state("midrst");
        rstn = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("post-reset rf_we", {31'd0, rf_we}, 32'd0);
        end
        chk("post-reset rf_busy", rf_busy, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
